// File: rtl/keep_one_in_n_unzip_if.sv
// AXI-Stream style bundle (data, last, valid, ready) shared by the packed and unpacked sides
// of keep_one_in_n_unzip.
interface keep_one_in_n_unzip_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] tdata;
   logic             tlast;
   logic             tvalid;
   logic             tready;

   modport master (output tdata, output tlast, output tvalid, input  tready);
   modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/keep_one_in_n_unzip.sv
// Unpacks one 32-bit word of four 8-bit IQ symbols into four {I16, Q16} samples, byte 0 first.
// Optional build macro ROUND_HALF_EN fills half an LSB (I[8], Q[8]) into each expanded sample.
//
// state    | meaning
// ST_EMPTY | no word held, input ready
// ST_FULL  | hold valid, lane_q is the symbol currently on the output
module keep_one_in_n_unzip #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   keep_one_in_n_unzip_if.slave  s_axis,
   keep_one_in_n_unzip_if.master m_axis
);

   if (WIDTH != 32) begin : g_bad_width
      $error("keep_one_in_n_unzip: only WIDTH=32 is supported");
   end

`ifdef ROUND_HALF_EN
   localparam logic HALF_LSB = 1'b1;
`else
   localparam logic HALF_LSB = 1'b0;
`endif

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] hold_q, hold_d;
   logic        hold_last_q, hold_last_d;

   logic        full;
   logic        last_lane;
   logic        in_fire;
   logic        out_fire;
   logic [7:0]  cur_byte;

   function automatic logic [31:0] expand(input logic [7:0] b);
      return {{4{b[7]}}, b[6:4], HALF_LSB, 8'b0, {4{b[3]}}, b[2:0], HALF_LSB, 8'b0};
   endfunction

   assign full      = (state_q == ST_FULL);
   assign last_lane = (lane_q == 2'd3);
   // Ready depends only on held state and o_tready so there is no valid->ready loop.
   assign s_axis.tready = ~full | (last_lane & m_axis.tready);
   assign in_fire   = s_axis.tvalid & s_axis.tready;
   assign out_fire  = full & m_axis.tready;

   always_comb begin
      cur_byte = hold_q[7:0];
      case (lane_q)
         2'd0: cur_byte = hold_q[7:0];
         2'd1: cur_byte = hold_q[15:8];
         2'd2: cur_byte = hold_q[23:16];
         2'd3: cur_byte = hold_q[31:24];
         default: cur_byte = hold_q[7:0];
      endcase
   end

   assign m_axis.tvalid = full;
   assign m_axis.tdata  = full ? expand(cur_byte) : 32'h0;
   assign m_axis.tlast  = full & last_lane & hold_last_q;

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      hold_d      = hold_q;
      hold_last_d = hold_last_q;
      if (in_fire) begin
         // Covers both the idle load and the bubble-free reload on the lane-3 handoff.
         hold_d      = s_axis.tdata;
         hold_last_d = s_axis.tlast;
         lane_d      = 2'd0;
         state_d     = ST_FULL;
      end else if (out_fire) begin
         if (last_lane) begin
            lane_d  = 2'd0;
            state_d = ST_EMPTY;
         end else begin
            lane_d  = lane_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         lane_q      <= 2'd0;
         hold_q      <= 32'h0;
         hold_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         hold_q      <= hold_d;
         hold_last_q <= hold_last_d;
      end
   end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Scoreboard bench for keep_one_in_n_unzip: randomized words in, expanded samples checked
// against an arithmetic reference model; also covers latency, streaming, stalls and reset.
module tb_keep_one_in_n_unzip;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   keep_one_in_n_unzip_if #(.WIDTH(32)) in_if ();
   keep_one_in_n_unzip_if #(.WIDTH(32)) out_if ();

   keep_one_in_n_unzip #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .s_axis (in_if),
      .m_axis (out_if)
   );

`ifdef ROUND_HALF_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   mon_lane = 0;
   bit   prev_stall = 0;
   logic [31:0] prev_d;
   logic        prev_l;

   bit          pend = 0;
   logic [31:0] pw;
   logic        pl;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   // Symbol nibble is a signed 4-bit value in units of 512 (2^9) on the 16-bit component.
   function automatic logic [15:0] model_comp(input int nib);
      int v;
      v = (nib >= 8) ? nib - 16 : nib;
      v = v * 512 + (ROUND ? 256 : 0);
      return v[15:0];
   endfunction

   function automatic logic [31:0] model_sample(input logic [7:0] b);
      return {model_comp(int'(b[7:4])), model_comp(int'(b[3:0]))};
   endfunction

   task automatic push_word(input logic [31:0] w, input logic last);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.d = model_sample(w[8*k +: 8]);
         e.l = last && (k == 3);
         sb.push_back(e);
      end
   endtask

   // Monitor: pops and compares on every output fire, checks stalls and ready rules.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk(out_if.tdata == prev_d, "stall_data_stable", out_if.tdata, prev_d);
               chk(out_if.tlast == prev_l, "stall_last_stable", {31'b0, out_if.tlast}, {31'b0, prev_l});
            end
            if (out_if.tvalid)
               chk(in_if.tready == (mon_lane == 3 && out_if.tready), "i_tready_busy",
                   {31'b0, in_if.tready}, {31'b0, (mon_lane == 3 && out_if.tready)});
            else
               chk(in_if.tready == 1'b1, "i_tready_idle", {31'b0, in_if.tready}, 32'd1);
            if (out_if.tvalid && out_if.tready) begin
               if (sb.size() == 0) begin
                  chk(1'b0, "unexpected_sample", out_if.tdata, 32'h0);
               end else begin
                  e = sb.pop_front();
                  chk(out_if.tdata == e.d, "sample_data", out_if.tdata, e.d);
                  chk(out_if.tlast == e.l, "sample_last", {31'b0, out_if.tlast}, {31'b0, e.l});
               end
               mon_lane = (mon_lane + 1) % 4;
            end
            prev_stall = out_if.tvalid && !out_if.tready;
            prev_d     = out_if.tdata;
            prev_l     = out_if.tlast;
         end
      end
   end

   // One clock of stimulus: a pending input word is held until accepted.
   task automatic step(input int pv, input int pr);
      @(posedge clk);
      #1;
      if (!pend && $urandom_range(99) < pv) begin
         pend = 1;
         pw   = $urandom;
         pl   = ($urandom_range(3) == 0);
      end
      in_if.tvalid   = pend;
      in_if.tdata    = pw;
      in_if.tlast    = pl;
      out_if.tready  = ($urandom_range(99) < pr);
      @(negedge clk);
      if (in_if.tvalid && in_if.tready) begin
         push_word(pw, pl);
         pend = 0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((pend || sb.size() != 0 || out_if.tvalid) && n < 300) begin
         step(0, 100);
         n++;
      end
      chk(n < 300, "drain_timeout", n, 300);
   endtask

   initial begin
      exp_t e;
      int   gaps;
      bit   seen;
      reset         = 1'b1;
      in_if.tvalid  = 1'b0;
      in_if.tdata   = 32'h0;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b0;
      pw = 32'h0;
      pl = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk(out_if.tvalid == 1'b0, "reset_o_tvalid", {31'b0, out_if.tvalid}, 32'd0);
      chk(out_if.tlast == 1'b0, "reset_o_tlast", {31'b0, out_if.tlast}, 32'd0);
      chk(out_if.tdata == 32'h0, "reset_o_tdata", out_if.tdata, 32'h0);
      chk(in_if.tready == 1'b1, "reset_i_tready", {31'b0, in_if.tready}, 32'd1);

      // Directed word with hand-computed samples and 1-cycle latency.
      @(posedge clk);
      #1;
      in_if.tvalid  = 1'b1;
      in_if.tdata   = 32'h80F71111;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b1;
      @(negedge clk);
      chk(in_if.tready == 1'b1, "directed_accept", {31'b0, in_if.tready}, 32'd1);
      e.l = 1'b0;
      e.d = ROUND ? 32'h03000300 : 32'h02000200; sb.push_back(e);
      e.d = ROUND ? 32'h03000300 : 32'h02000200; sb.push_back(e);
      e.d = ROUND ? 32'hFF000F00 : 32'hFE000E00; sb.push_back(e);
      e.d = ROUND ? 32'hF1000100 : 32'hF0000000; sb.push_back(e);
      @(posedge clk);
      #1 in_if.tvalid = 1'b0;
      @(negedge clk);
      chk(out_if.tvalid == 1'b1, "latency_one_cycle", {31'b0, out_if.tvalid}, 32'd1);
      drain();

      // Random valid/ready traffic.
      for (int i = 0; i < 500; i++) step(60, 50);
      drain();

      // Both sides always ready: output must never bubble once streaming.
      gaps = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         step(100, 100);
         if (seen && !out_if.tvalid) gaps++;
         if (out_if.tvalid) seen = 1;
      end
      chk(gaps == 0, "bubble_free", gaps, 0);
      drain();

      // Reset after lane 1 fires: remaining lanes discarded.
      @(posedge clk);
      #1;
      in_if.tvalid  = 1'b1;
      in_if.tdata   = 32'h12345678;
      in_if.tlast   = 1'b1;
      out_if.tready = 1'b1;
      @(negedge clk);
      if (in_if.tready) push_word(32'h12345678, 1'b1);
      chk(in_if.tready == 1'b1, "reset_word_accept", {31'b0, in_if.tready}, 32'd1);
      @(posedge clk);
      #1 in_if.tvalid = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      reset         = 1'b1;
      out_if.tready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      mon_lane = 0;
      @(negedge clk);
      chk(out_if.tvalid == 1'b0, "midreset_o_tvalid", {31'b0, out_if.tvalid}, 32'd0);
      chk(out_if.tdata == 32'h0, "midreset_o_tdata", out_if.tdata, 32'h0);
      chk(out_if.tlast == 1'b0, "midreset_o_tlast", {31'b0, out_if.tlast}, 32'd0);
      chk(in_if.tready == 1'b1, "midreset_i_tready", {31'b0, in_if.tready}, 32'd1);

      // Next word after reset must restart at lane 0.
      for (int i = 0; i < 30; i++) step(80, 70);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
